// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between the execute stage and mem_access_ctrl.
// master = requester (execute stage), slave = the controller.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        misalign_fault;
    logic        access_fault;

    modport master (
        output req_valid,
        output req_store,
        output req_funct3,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  misalign_fault,
        input  access_fault
    );

    modport slave (
        input  req_valid,
        input  req_store,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output misalign_fault,
        output access_fault
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store access controller in front of data_memory.
// Define MISALIGN_SPLIT_EN to split misaligned accesses instead of faulting.
module mem_access_ctrl (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus,
    output logic              dm_MemRead,
    output logic              dm_MemWrite,
    output logic [2:0]        dm_funct3,
    output logic [31:0]       dm_address,
    output logic [31:0]       dm_write_data,
    input  logic [31:0]       dm_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        ACC1,
        SBYTE,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        store_q;
    logic        afault_q;
    logic        mfault_q;

    logic        accept;
    logic        req_legal;
    logic        req_mis;

`ifdef MISALIGN_SPLIT_EN
    logic        mis_q;
    logic [1:0]  k_q;
    logic [1:0]  k_last;
    logic [31:0] w0_q;
    logic [31:0] merged;
    logic [31:0] merge_raw;
    logic [7:0]  sbyte;
`endif

    assign accept = bus.req_valid && (state == IDLE);

    always_comb begin
        req_legal = 1'b0;
        unique case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = !bus.req_store;
            default:                req_legal = 1'b0;
        endcase
    end

    always_comb begin
        req_mis = 1'b0;
        unique case (1'b1)
            bus.req_funct3[1:0] == 2'b01: req_mis = bus.req_addr[0];
            bus.req_funct3[1:0] == 2'b10: req_mis = |bus.req_addr[1:0];
            default:                      req_mis = 1'b0;
        endcase
    end

`ifdef MISALIGN_SPLIT_EN
    // Second word arrives combinationally in ACC1; merge it with w0 here.
    assign merge_raw = 32'({dm_read_data, w0_q} >> {addr_q[1:0], 3'b000});
    assign k_last    = f3_q[1] ? 2'd3 : 2'd1;
    assign sbyte     = 8'(wdata_q >> {k_q, 3'b000});

    always_comb begin
        merged = merge_raw;
        unique case (f3_q)
            3'b001:  merged = {{16{merge_raw[15]}}, merge_raw[15:0]};
            3'b101:  merged = {16'h0000, merge_raw[15:0]};
            default: merged = merge_raw;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_legal) begin
                        state_nx = RESP;
                    end else if (req_mis) begin
`ifdef MISALIGN_SPLIT_EN
                        state_nx = bus.req_store ? SBYTE : ACC0;
`else
                        state_nx = RESP;
`endif
                    end else begin
                        state_nx = ACC0;
                    end
                end
            end
            ACC0: begin
`ifdef MISALIGN_SPLIT_EN
                state_nx = mis_q ? ACC1 : RESP;
`else
                state_nx = RESP;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            ACC1: state_nx = RESP;
            SBYTE: begin
                if (k_q == k_last) begin
                    state_nx = RESP;
                end
            end
`endif
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready      = (state == IDLE);
        bus.resp_valid     = (state == RESP);
        bus.resp_rdata     = 32'h0;
        bus.misalign_fault = 1'b0;
        bus.access_fault   = 1'b0;
        dm_MemRead         = 1'b0;
        dm_MemWrite        = 1'b0;
        dm_funct3          = 3'b000;
        dm_address         = 32'h0;
        dm_write_data      = 32'h0;
        unique case (state)
            ACC0: begin
`ifdef MISALIGN_SPLIT_EN
                if (mis_q) begin
                    dm_MemRead = 1'b1;
                    dm_funct3  = 3'b010;
                    dm_address = {addr_q[31:2], 2'b00};
                end else begin
                    dm_MemRead    = !store_q;
                    dm_MemWrite   = store_q;
                    dm_funct3     = f3_q;
                    dm_address    = addr_q;
                    dm_write_data = wdata_q;
                end
`else
                dm_MemRead    = !store_q;
                dm_MemWrite   = store_q;
                dm_funct3     = f3_q;
                dm_address    = addr_q;
                dm_write_data = wdata_q;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            ACC1: begin
                dm_MemRead = 1'b1;
                dm_funct3  = 3'b010;
                dm_address = {addr_q[31:2] + 30'd1, 2'b00};
            end
            SBYTE: begin
                dm_MemWrite   = 1'b1;
                dm_funct3     = 3'b000;
                dm_address    = addr_q + {30'd0, k_q};
                dm_write_data = {24'h0, sbyte};
            end
`endif
            RESP: begin
                bus.resp_rdata     = rdata_q;
                bus.misalign_fault = mfault_q;
                bus.access_fault   = afault_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f3_q     <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            store_q  <= 1'b0;
            afault_q <= 1'b0;
            mfault_q <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            mis_q    <= 1'b0;
            k_q      <= 2'd0;
            w0_q     <= 32'h0;
`endif
        end else begin
            if (accept) begin
                f3_q     <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                store_q  <= bus.req_store;
                rdata_q  <= 32'h0;
                afault_q <= !req_legal;
`ifdef MISALIGN_SPLIT_EN
                mfault_q <= 1'b0;
                mis_q    <= req_legal && req_mis;
                k_q      <= 2'd0;
`else
                mfault_q <= req_legal && req_mis;
`endif
            end
            if (state == ACC0 && !store_q) begin
`ifdef MISALIGN_SPLIT_EN
                if (mis_q) begin
                    w0_q <= dm_read_data;
                end else begin
                    rdata_q <= dm_read_data;
                end
`else
                rdata_q <= dm_read_data;
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            if (state == ACC1) begin
                rdata_q <= merged;
            end
            if (state == SBYTE) begin
                k_q <= k_q + 2'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-array data_memory model.
// Expectations follow MISALIGN_SPLIT_EN the same way the design does.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        dm_MemRead;
    logic        dm_MemWrite;
    logic [2:0]  dm_funct3;
    logic [31:0] dm_address;
    logic [31:0] dm_write_data;
    logic [31:0] dm_read_data;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .dm_MemRead    (dm_MemRead),
        .dm_MemWrite   (dm_MemWrite),
        .dm_funct3     (dm_funct3),
        .dm_address    (dm_address),
        .dm_write_data (dm_write_data),
        .dm_read_data  (dm_read_data)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:1023];
    logic [31:0] rd_addr [0:255];
    logic [31:0] wr_addr [0:255];
    logic [31:0] wr_data [0:255];
    int          nrd;
    int          nwr;
    int          both_cnt;
    int          idle_bad;

    initial begin
        nrd      = 0;
        nwr      = 0;
        both_cnt = 0;
        idle_bad = 0;
    end

    logic [9:0] ab;
    logic [7:0] b0, b1, b2, b3;

    always_comb begin
        ab = dm_address[9:0];
        b0 = mem[ab];
        b1 = mem[ab + 10'd1];
        b2 = mem[ab + 10'd2];
        b3 = mem[ab + 10'd3];
        dm_read_data = {b3, b2, b1, b0};
        case (dm_funct3)
            3'b000:  dm_read_data = {{24{b0[7]}}, b0};
            3'b100:  dm_read_data = {24'h0, b0};
            3'b001:  dm_read_data = {{16{b1[7]}}, b1, b0};
            3'b101:  dm_read_data = {16'h0, b1, b0};
            default: dm_read_data = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (dm_MemWrite === 1'b1) begin
            mem[ab] <= dm_write_data[7:0];
            if (dm_funct3[1:0] != 2'b00) begin
                mem[ab + 10'd1] <= dm_write_data[15:8];
            end
            if (dm_funct3[1:0] == 2'b10) begin
                mem[ab + 10'd2] <= dm_write_data[23:16];
                mem[ab + 10'd3] <= dm_write_data[31:24];
            end
            wr_addr[nwr[7:0]] <= dm_address;
            wr_data[nwr[7:0]] <= dm_write_data;
            nwr <= nwr + 1;
        end
        if (dm_MemRead === 1'b1) begin
            rd_addr[nrd[7:0]] <= dm_address;
            nrd <= nrd + 1;
        end
        if (dm_MemRead === 1'b1 && dm_MemWrite === 1'b1) begin
            both_cnt <= both_cnt + 1;
        end
        if (dm_MemRead === 1'b0 && dm_MemWrite === 1'b0 &&
            {dm_address, dm_write_data, dm_funct3} !== 67'h0) begin
            idle_bad <= idle_bad + 1;
        end
    end

    int          checks = 0;
    int          errors = 0;
    int          lat;
    int          rb;
    int          wb;
    int          nrd_d;
    int          nwr_d;
    logic [31:0] r_rd;
    logic        r_mf;
    logic        r_af;
    logic        r_ready;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        rb = nrd;
        wb = nwr;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_store  = ~st;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = 32'hA5A5A5A5;
        bus.req_wdata  = 32'h5A5A5A5A;
        lat     = 0;
        r_rd    = 32'h0;
        r_mf    = 1'b0;
        r_af    = 1'b0;
        r_ready = 1'b0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            if (bus.resp_valid === 1'b1) begin
                lat     = n;
                r_rd    = bus.resp_rdata;
                r_mf    = bus.misalign_fault;
                r_af    = bus.access_fault;
                r_ready = bus.req_ready;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("resp_seen", 32'(lat != 0), 32'd1);
        chk("ready_in_resp", 32'(r_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_resp", 32'(bus.req_ready), 32'd1);
        nrd_d = nrd - rb;
        nwr_d = nwr - wb;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_faults", {30'd0, bus.misalign_fault, bus.access_fault}, 32'd0);
        chk("rst_dm_rw", {30'd0, dm_MemRead, dm_MemWrite}, 32'd0);
        chk("rst_dm_addr", dm_address, 32'h0);
        chk("rst_dm_wdata", dm_write_data, 32'h0);
        chk("rst_dm_f3", 32'(dm_funct3), 32'd0);

        // Aligned store then load
        req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw_lat", lat, 2);
        chk("sw_writes", nwr_d, 1);
        chk("sw_rdata", r_rd, 32'h0);
        chk("sw_fault", {30'd0, r_mf, r_af}, 32'd0);
        req(1'b0, 3'b010, 32'h100, 32'h0);
        chk("lw_lat", lat, 2);
        chk("lw_rdata", r_rd, 32'hDEADBEEF);
        chk("lw_reads", nrd_d, 1);

        req(1'b1, 3'b010, 32'h100, 32'h44332211);
        req(1'b1, 3'b010, 32'h104, 32'h887766F5);
        req(1'b0, 3'b000, 32'h104, 32'h0);
        chk("lb_neg", r_rd, 32'hFFFFFFF5);
        req(1'b0, 3'b100, 32'h104, 32'h0);
        chk("lbu", r_rd, 32'h000000F5);
        req(1'b0, 3'b001, 32'h106, 32'h0);
        chk("lh_aligned", r_rd, 32'hFFFF8877);
        chk("lh_aligned_lat", lat, 2);

        req(1'b0, 3'b010, 32'h101, 32'h0);
`ifdef MISALIGN_SPLIT_EN
        chk("mlw_rdata", r_rd, 32'hF5443322);
        chk("mlw_lat", lat, 3);
        chk("mlw_reads", nrd_d, 2);
        chk("mlw_addr0", rd_addr[rb[7:0]], 32'h100);
        chk("mlw_addr1", rd_addr[8'(rb + 1)], 32'h104);
        chk("mlw_mfault", 32'(r_mf), 32'd0);
`else
        chk("mlw_mfault", 32'(r_mf), 32'd1);
        chk("mlw_lat", lat, 1);
        chk("mlw_reads", nrd_d, 0);
        chk("mlw_rdata", r_rd, 32'h0);
`endif
        req(1'b0, 3'b001, 32'h103, 32'h0);
`ifdef MISALIGN_SPLIT_EN
        chk("mlh_rdata", r_rd, 32'hFFFFF544);
        chk("mlh_lat", lat, 3);
`else
        chk("mlh_mfault", 32'(r_mf), 32'd1);
        chk("mlh_lat", lat, 1);
`endif
        req(1'b0, 3'b101, 32'h103, 32'h0);
`ifdef MISALIGN_SPLIT_EN
        chk("mlhu_rdata", r_rd, 32'h0000F544);
`else
        chk("mlhu_mfault", 32'(r_mf), 32'd1);
        chk("mlhu_rdata", r_rd, 32'h0);
`endif

        req(1'b1, 3'b010, 32'h200, 32'h0);
        req(1'b1, 3'b010, 32'h204, 32'h0);
        req(1'b1, 3'b010, 32'h202, 32'hA1B2C3D4);
`ifdef MISALIGN_SPLIT_EN
        chk("msw_lat", lat, 5);
        chk("msw_writes", nwr_d, 4);
        chk("msw_addr0", wr_addr[wb[7:0]], 32'h202);
        chk("msw_data0", wr_data[wb[7:0]], 32'h000000D4);
        chk("msw_addr3", wr_addr[8'(wb + 3)], 32'h205);
        chk("msw_data3", wr_data[8'(wb + 3)], 32'h000000A1);
        req(1'b0, 3'b010, 32'h200, 32'h0);
        chk("msw_rb0", r_rd, 32'hC3D40000);
        req(1'b0, 3'b010, 32'h204, 32'h0);
        chk("msw_rb1", r_rd, 32'h0000A1B2);
`else
        chk("msw_lat", lat, 1);
        chk("msw_mfault", 32'(r_mf), 32'd1);
        chk("msw_writes", nwr_d, 0);
        req(1'b0, 3'b010, 32'h200, 32'h0);
        chk("msw_rb0", r_rd, 32'h0);
`endif
        req(1'b1, 3'b001, 32'h301, 32'h0000BEEF);
`ifdef MISALIGN_SPLIT_EN
        chk("msh_lat", lat, 3);
        chk("msh_writes", nwr_d, 2);
        chk("msh_data1", wr_data[8'(wb + 1)], 32'h000000BE);
`else
        chk("msh_lat", lat, 1);
        chk("msh_writes", nwr_d, 0);
`endif
`ifdef MISALIGN_SPLIT_EN
        req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
        chk("wrap_lat", lat, 3);
        chk("wrap_addr0", rd_addr[rb[7:0]], 32'hFFFFFFFC);
        chk("wrap_addr1", rd_addr[8'(rb + 1)], 32'h00000000);
`endif

        // Illegal funct3
        req(1'b0, 3'b011, 32'h100, 32'h0);
        chk("af_load_flag", {30'd0, r_mf, r_af}, 32'd1);
        chk("af_load_lat", lat, 1);
        chk("af_load_reads", nrd_d, 0);
        chk("af_load_rdata", r_rd, 32'h0);
        req(1'b1, 3'b100, 32'h100, 32'h12345678);
        chk("af_store_flag", 32'(r_af), 32'd1);
        chk("af_store_writes", nwr_d, 0);
        req(1'b0, 3'b110, 32'h102, 32'h0);
        chk("af_f110_flags", {30'd0, r_mf, r_af}, 32'd1);

        // Byte store at an odd address is always aligned
        req(1'b1, 3'b000, 32'h105, 32'hFFFFFF5A);
        chk("sb_odd_lat", lat, 2);
        chk("sb_odd_mf", 32'(r_mf), 32'd0);
        req(1'b0, 3'b010, 32'h104, 32'h0);
        chk("sb_odd_rb", r_rd, 32'h88775AF5);

        // Reset during an aligned store access
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h300;
        bus.req_wdata  = 32'h12345678;
        wb = nwr;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("rst_acc0_write", 32'(dm_MemWrite), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_acc0_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_acc0_resp", 32'(bus.resp_valid), 32'd0);
        chk("rst_acc0_dm", {29'd0, dm_MemRead, dm_MemWrite, |dm_address}, 32'd0);
        chk("rst_acc0_writes", nwr - wb, 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_acc0_noresp", 32'(bus.resp_valid), 32'd0);
        req(1'b0, 3'b010, 32'h300, 32'h0);
        chk("rst_acc0_rb", r_rd, 32'h12345678);

`ifdef MISALIGN_SPLIT_EN
        // Reset during SBYTE after two bytes
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h202;
        bus.req_wdata  = 32'h11223344;
        wb = nwr;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_sb_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_sb_resp", 32'(bus.resp_valid), 32'd0);
        chk("rst_sb_rw", {30'd0, dm_MemRead, dm_MemWrite}, 32'd0);
        chk("rst_sb_addr", dm_address, 32'h0);
        chk("rst_sb_wdata", dm_write_data, 32'h0);
        chk("rst_sb_f3", 32'(dm_funct3), 32'd0);
        chk("rst_sb_writes", nwr - wb, 2);
        @(negedge clk);
        reset = 1'b0;
        req(1'b0, 3'b010, 32'h200, 32'h0);
        chk("rst_sb_rb", r_rd, 32'h33440000);
`endif

        chk("rw_overlap", both_cnt, 0);
        chk("dm_idle_nonzero", idle_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store access controller between the execute stage and `data_memory`. It accepts one load or store request at a time over a valid/ready handshake and issues the memory-side accesses. Naturally aligned requests pass through as a single access. Misaligned loads are split into two word reads and merged; misaligned stores are split into byte writes. Results and completion are returned as a registered one-cycle response.

## Interface
- No parameters.
- `clk` input 1 — system clock, rising edge.
- `reset` input 1 — synchronous, active-high.
- `req_valid` input 1 — request present.
- `req_ready` output 1 — controller can accept; high only in IDLE.
- `req_store` input 1 — 1 = store, 0 = load.
- `req_funct3` input 3 — RV32I load/store funct3.
- `req_addr` input 32 — byte address.
- `req_wdata` input 32 — store data, right-aligned.
- `resp_valid` output 1 — one-cycle completion pulse.
- `resp_rdata` output 32 — load result, extended per funct3; 0 for stores and faults.
- `misalign_fault` output 1 — valid with `resp_valid`.
- `access_fault` output 1 — valid with `resp_valid`.
- `dm_MemRead`, `dm_MemWrite` output 1 — to `data_memory`.
- `dm_funct3` output 3, `dm_address` output 32, `dm_write_data` output 32 — to `data_memory`.
- `dm_read_data` input 32 — combinational read data from `data_memory`.

## Operation
- States: IDLE, ACC0, ACC1, SBYTE, RESP.
- Accept: a request is accepted when `req_valid && req_ready`. Funct3, address, data and store flag are latched at acceptance, so the requester need not hold them afterwards.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else → go to RESP with `access_fault`=1 and no memory access.
- Misaligned is defined as:
  - halfword (001/101) with `addr[0]`=1;
  - word (010) with `addr[1:0]`≠0.
- Byte accesses are never misaligned.
- Aligned request:
  - IDLE→ACC0.
  - ACC0 drives `dm_*` with the original funct3, address and data.
  - A load captures `dm_read_data` into `resp_rdata`.
  - ACC0→RESP.
- Misaligned load:
  - ACC0 issues LW (010) at `{addr[31:2],2'b00}` and captures w0.
  - ACC1 issues LW at `{addr[31:2]+1,2'b00}`; the address wraps modulo 2^32.
  - Merge: `({w1,w0} >> 8*addr[1:0])[31:0]`, truncated to 16 bits for halfwords, then sign- or zero-extended per funct3.
  - ACC1→RESP.
- Misaligned store:
  - SBYTE issues SB (000) for byte k = 0..n-1, where n=2 for SH and n=4 for SW.
  - Address is `addr+k`; data byte is `wdata[8k+7:8k]`.
  - A 2-bit counter k increments each cycle; leave after byte n-1 → RESP.
- RESP:
  - `resp_valid`=1 for exactly one cycle, then →IDLE.
  - Stores return `resp_rdata`=0.
- `dm_MemRead`/`dm_MemWrite` are 0 in IDLE and RESP. `dm_address`, `dm_write_data` and `dm_funct3` are 0 whenever neither is asserted.
- At most one of `dm_MemRead` and `dm_MemWrite` is high in any cycle.

## Timing
- Request accepted at edge E0; cycle 1 is the cycle following E0.
- Latencies (`resp_valid` cycle):
  - aligned access: 2;
  - misaligned load: 3;
  - misaligned SH: 3;
  - misaligned SW: 5;
  - fault: 1.
- Memory writes occur at the end of each write cycle. Load data is sampled at the end of each read cycle.
- `req_ready`=1 only in IDLE, so the next acceptance is possible in the cycle after RESP.
- Reset values:
  - state IDLE;
  - `req_ready`=1;
  - `resp_valid`=0, `resp_rdata`=0, both faults 0;
  - all `dm_*`=0;
  - counter 0.
- Reset mid-operation (any state): IDLE on the next cycle and no response is issued. Bytes already written stay written.

## Configuration
- `MISALIGN_SPLIT_EN` defined: misaligned requests are split as described above.
- `MISALIGN_SPLIT_EN` undefined:
  - misaligned requests go IDLE→RESP with `misalign_fault`=1, `resp_rdata`=0, no memory access, latency 1;
  - ACC1 and SBYTE are not built.

## Test plan
- Store then load, aligned: SW 0xDEADBEEF @0x100, then LW @0x100 → `resp_rdata`=0xDEADBEEF, `resp_valid` in cycle 2 for each request.
- Misaligned LW: memory 0x100=0x44332211, 0x104=0x887766F5; LW @0x101 → 0xF5443322 in cycle 3; exactly two `dm_MemRead` cycles, at 0x100 then 0x104.
- Misaligned LH/LHU, same memory contents:
  - LH @0x103 → 0xFFFFF544;
  - LHU @0x103 → 0x0000F544.
- Misaligned SW: SW 0xA1B2C3D4 @0x202 → four SB cycles at 0x202..0x205 with bytes D4,C3,B2,A1, `resp_valid` in cycle 5. Readback:
  - LW @0x200 → 0xC3D40000;
  - LW @0x204 → 0x0000A1B2.
- Faults:
  - load funct3=011 @0x100 → `access_fault`=1, `resp_valid` in cycle 1, no `dm_MemRead`;
  - with the macro undefined, LW @0x101 → `misalign_fault`=1 in cycle 1, no access.
- Reset mid-store: assert `reset` during SBYTE after 2 bytes of SW @0x202 → next cycle `req_ready`=1, `resp_valid`=0, all `dm_*`=0.
